out_bcd_conv: RTL and testbench
===============================

# out_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the CPU's `out` port and feeds the board display drivers. It watches the CPU output word and starts a conversion whenever the word changes. It runs a shift-and-add-3 (double-dabble) conversion, one bit per clock, and holds the last completed decimal result stable on its outputs. A one-cycle `valid` pulse marks each update.

## Interface
- `DATA_WIDTH`, 16: width of the binary input word.
- `DIGITS`, 5: number of BCD digits produced. Must satisfy 10^DIGITS > 2^DATA_WIDTH.

- `clk`  input  1  system clock; all state changes on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in`  input  DATA_WIDTH  binary word from the CPU `out` port.
- `digits`  output  4*DIGITS  BCD result; digit 0 (ones) in bits [3:0], most significant digit in the top nibble.
- `valid`  output  1  one-cycle pulse: `digits` was updated on the preceding edge.
- `busy`  output  1  high while a conversion is in progress.
- `neg`  output  1  sign of the displayed value. Functional only with `OUT_BCD_SIGNED_EN` (see Configuration); otherwise tied to 0.

## Operation
- Registers:
  - `last`: DATA_WIDTH bits, the last value accepted for conversion.
  - `op`: DATA_WIDTH-bit shift operand.
  - `scratch`: 4*DIGITS bits.
  - bit counter: $clog2(DATA_WIDTH+1) bits.
  - state.
- FSM states: `IDLE`, `CONV`.
- `IDLE`:
  - If `in != last`: `op <= in`, `last <= in`, `scratch <= 0`, `cnt <= 0`, go to `CONV`.
  - Otherwise stay in `IDLE`.
- `CONV`, each cycle, one iteration:
  1. Every scratch nibble ≥ 5 gets +3. All nibbles are corrected in parallel, combinationally.
  2. `{scratch, op}` shifts left by 1; the MSB of `op` enters `scratch[0]`.
  3. `cnt <= cnt + 1`.
- Completion: the iteration with `cnt == DATA_WIDTH-1` also loads the shifted scratch into `digits`, sets `valid <= 1` and returns to `IDLE`.
- `busy` = (state == `CONV`).
- `in` is not sampled during `CONV`. If `in` changes during a conversion, the new value is picked up on the first `IDLE` cycle afterwards, so the final value is always displayed.
- Reset values (asynchronous):
  - state `IDLE`; `last`, `op`, `scratch`, `cnt` = 0.
  - `digits` = 0, `valid` = 0, `busy` = 0, `neg` = 0.
  - Because `last` resets to 0, a zero input after reset triggers no conversion; this matches the CPU's reset output of 0.

## Timing
- `in` changes and is sampled at edge E0, which enters `CONV`.
- Edges E1..E(DATA_WIDTH) each perform one iteration.
- `digits` updates at edge E(DATA_WIDTH); `valid` is high for the cycle that follows that edge.
- Total latency is DATA_WIDTH+1 edges: 17 for the default width.
- `busy` is high from E0 until E(DATA_WIDTH).
- Minimum spacing between two conversions is DATA_WIDTH+2 edges; `IDLE` always lasts at least one cycle.
- `digits` never shows a partial result; it changes only at completion.
- Reset asserted mid-conversion: the conversion is aborted immediately, outputs return to their reset values, and no `valid` pulse is produced.
- Back-to-back: `valid` and the next `IDLE` compare fall in the same cycle; the new `CONV` starts on the following edge.

## Configuration
- `OUT_BCD_SIGNED_EN` defined:
  - `in` is treated as two's complement.
  - At load: `op <= in[MSB] ? -in : in`, and a sign register is set to `in[MSB]`.
  - The sign register is copied to `neg` at completion, in the same edge as `digits`.
  - -2^(DATA_WIDTH-1) converts as magnitude 2^(DATA_WIDTH-1) with `neg` = 1.
- Not defined:
  - `in` is unsigned, `op <= in`, and `neg` is constant 0.
  - No negate logic or sign register is synthesized.

## Test plan
- Reset with `in` = 0 → `digits` = 0x00000, `valid` never pulses, `busy` = 0.
- `in` = 12345 (0x3039) → `busy` high for 16 cycles; at edge 17 `digits` = 0x12345; `valid` pulses exactly once.
- `in` = 65535 (unsigned build) → `digits` = 0x65535. `in` = 0xFFFF with `OUT_BCD_SIGNED_EN` → `digits` = 0x00001, `neg` = 1. `in` = 0x8000 (signed build) → `digits` = 0x32768, `neg` = 1.
- `in` = 10, then `in` = 20 five cycles later (mid-conversion):
  - first completion gives `digits` = 0x00010 with a `valid` pulse;
  - then a second conversion gives `digits` = 0x00020 and a second `valid` pulse;
  - two pulses in total.
- `in` = 999 with `rst_n` pulled low at the 8th conversion cycle, then released with `in` held → outputs are 0 during reset. After release, a new conversion yields `digits` = 0x00999 17 edges after the first sampling edge.
- `in` held constant at 42 after its conversion for 100 cycles → no further `busy` or `valid` activity; `digits` remains 0x00042.

Source files
------------

// File: rtl/out_bcd_conv.sv
// out_bcd_conv: sequential binary-to-BCD converter (shift-and-add-3, one bit
// per clock) watching the CPU output word. A conversion starts whenever the
// input differs from the last accepted value; the finished decimal result is
// held on `digits` with a one-cycle `valid` pulse.
// Optional feature: define OUT_BCD_SIGNED_EN to treat `in` as two's complement
// and report the sign on `neg` (otherwise `neg` is constant 0).
module out_bcd_conv #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in,
  output logic [4*DIGITS-1:0]     digits,
  output logic                    valid,
  output logic                    busy,
  output logic                    neg
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] last;
  logic [DATA_WIDTH-1:0] op;
  logic [SW-1:0]         scratch;
  logic [CW-1:0]         cnt;

  logic [SW-1:0]         adj;
  logic [SW-1:0]         scratch_shift;
  logic [DATA_WIDTH-1:0] op_shift;
  logic [DATA_WIDTH-1:0] load_op;
  logic                  last_iter;

  // Add-3 correction on every nibble in parallel before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch[4*gi +: 4] >= 4'd5) ?
                              (scratch[4*gi +: 4] + 4'd3) :
                               scratch[4*gi +: 4];
    end
  endgenerate

  // The MSB of the operand shifts into the bottom of the BCD scratch.
  assign scratch_shift = {adj[SW-2:0], op[DATA_WIDTH-1]};
  assign op_shift      = {op[DATA_WIDTH-2:0], 1'b0};
  assign last_iter     = (cnt == CW'(DATA_WIDTH - 1));

`ifdef OUT_BCD_SIGNED_EN
  logic sign;

  // Magnitude of a two's complement input; the most negative value maps to
  // 2^(DATA_WIDTH-1), which still fits as an unsigned operand.
  assign load_op = in[DATA_WIDTH-1] ? (-in) : in;

  // Capture the sign at load and publish it together with the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
      neg  <= 1'b0;
    end else if (state == IDLE) begin
      if (in != last) sign <= in[DATA_WIDTH-1];
    end else if (last_iter) begin
      neg <= sign;
    end
  end
`else
  assign load_op = in;
  assign neg     = 1'b0;
`endif

  // Conversion FSM: load on input change, one double-dabble step per cycle,
  // registered busy/valid/digits outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= '0;
      op      <= '0;
      scratch <= '0;
      cnt     <= '0;
      digits  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in != last) begin
            op      <= load_op;
            last    <= in;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= scratch_shift;
          op      <= op_shift;
          cnt     <= cnt + 1'b1;
          if (last_iter) begin
            digits <= scratch_shift;
            valid  <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_bcd_conv.sv
// Testbench for out_bcd_conv: scoreboard of expected decimal results fed by
// the stimulus process, checked by an independent monitor on each valid pulse.
module tb_out_bcd_conv;

  localparam int DW  = 16;
  localparam int DG  = 5;
  localparam int LAT = DW + 1;

  logic              clk;
  logic              rst_n;
  logic [DW-1:0]     in_word;
  logic [4*DG-1:0]   digits;
  logic              valid;
  logic              busy;
  logic              neg;

  typedef struct {
    logic [4*DG-1:0] dig;
    logic            sgn;
    int              issue;  // cycle of issue, -1 if latency not checked
    int              value;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   busy_cnt = 0;
  logic [DW-1:0] model_last = '0;

  out_bcd_conv #(.DATA_WIDTH(DW), .DIGITS(DG)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in_word),
    .digits (digits),
    .valid  (valid),
    .busy   (busy),
    .neg    (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Decimal digits of a magnitude by plain division.
  function automatic logic [4*DG-1:0] to_bcd(input int unsigned m);
    logic [4*DG-1:0] r;
    int unsigned     v;
    r = '0;
    v = m;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [DW-1:0] v, input int issue);
    exp_t e;
    int unsigned mag;
`ifdef OUT_BCD_SIGNED_EN
    if (v[DW-1]) begin
      mag   = (1 << DW) - int'(v);
      e.sgn = 1'b1;
    end else begin
      mag   = int'(v);
      e.sgn = 1'b0;
    end
`else
    mag   = int'(v);
    e.sgn = 1'b0;
`endif
    e.dig   = to_bcd(mag);
    e.issue = issue;
    e.value = int'(v);
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each valid pulse, flags stray activity.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL busy_unexpected: got busy=1 expected 0 (cycle %0d)", cyc);
        end
      end
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL valid_unexpected: got valid=1 digits=%h expected no pulse", digits);
        end else begin
          e = q.pop_front();
          $display("txn in=%0h digits=%h neg=%0d exp=%h/%0d", e.value, digits, neg, e.dig, e.sgn);
          chk("digits", longint'(digits), longint'(e.dig));
          chk("neg", longint'(neg), longint'(e.sgn));
          chk("busy_cycles", longint'(busy_cnt), longint'(DW));
          if (e.issue >= 0)
            chk("latency", longint'(cyc - e.issue), longint'(LAT));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
  endtask

  // Drive a new word; a conversion is expected only when it differs.
  task automatic issue(input logic [DW-1:0] v, input bit check_lat);
    @(posedge clk);
    #1;
    in_word = v;
    if (v != model_last) begin
      q.push_back(model(v, check_lat ? cyc : -1));
      model_last = v;
    end
  endtask

  initial begin
    logic [DW-1:0] vals[6];
    rst_n   = 1'b0;
    in_word = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", longint'(digits), 0);
    chk("rst_valid", longint'(valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_neg", longint'(neg), 0);
    rst_n = 1'b1;
    // Zero after reset must not start anything (monitor flags stray busy).
    repeat (5) @(posedge clk);

    vals[0] = 16'd12345; vals[1] = 16'hFFFF; vals[2] = 16'h8000;
    vals[3] = 16'd0;     vals[4] = 16'd9;    vals[5] = 16'd9;
    foreach (vals[i]) begin
      issue(vals[i], 1'b1);
      wait_drain();
    end

    for (int i = 0; i < 20; i++) begin
      issue(16'($urandom_range(0, (1 << DW) - 1)), 1'b1);
      wait_drain();
    end

    // Input change in the middle of a conversion.
    issue(16'd10, 1'b1);
    repeat (4) @(posedge clk);
    issue(16'd20, 1'b0);
    wait_drain();

    // Reset during a conversion aborts it without a valid pulse.
    issue(16'd999, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    model_last = '0;
    #1;
    chk("abort_digits", longint'(digits), 0);
    chk("abort_valid", longint'(valid), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_neg", longint'(neg), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.push_back(model(16'd999, cyc));
    model_last = 16'd999;
    wait_drain();

    // Held value: no further activity, output stable.
    issue(16'd42, 1'b1);
    wait_drain();
    repeat (100) @(posedge clk);
    #1;
    chk("hold_digits", longint'(digits), longint'(to_bcd(42)));
    chk("hold_busy", longint'(busy), 0);
    chk("queue_empty", longint'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
